greedy_snake_dpb_r: RTL and testbench

GREEDY_SNAKE_DPB_R -- requirements
Module: greedy_snake_dpb_r

---
 rtl/greedy_snake_dpb_r.sv | 177 +++++++++++++++++
 tb/tb_greedy_snake_dpb_r.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/greedy_snake_dpb_r.sv
// greedy_snake_dpb_r
//   Walks a singly linked list of snake body nodes held in a Gowin_DPB
//   (channel B, read-only) and streams each node position out over a
//   valid/ready handshake.
//
//   Node layout (4 bytes at A..A+3):
//     byte0 position {x[7:4], y[3:0]}, byte1 ignored,
//     byte2[2:0] next[10:8], byte3 next[7:0]; next == 0 ends the list.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start, head_addr    traversal request and first node address
//   busy, done          traversal in progress / one-cycle end pulse
//   err, length         0 ok / 1 overflow / 2 misaligned next; node count
//   pos_valid/ready     node stream handshake; pos_data, pos_last payload
//   i_b_*               channel B request outputs (read-only use)
//   o_b_data            channel B read data, READ_LATENCY cycles after address
module greedy_snake_dpb_r #(
    parameter int READ_LATENCY = 2,
    parameter int MAX_NODES    = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [10:0] head_addr,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err,
    output logic [10:0] length,
    output logic        pos_valid,
    input  logic        pos_ready,
    output logic [7:0]  pos_data,
    output logic        pos_last,
    output logic        i_b_clk_en,
    output logic        i_b_data_en,
    output logic        i_b_wr_en,
    output logic [7:0]  i_b_data,
    output logic [10:0] i_b_address,
    input  logic [7:0]  o_b_data
);

    localparam int WCW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_OVF  = 2'd1;
    localparam logic [1:0] ERR_MIS  = 2'd2;

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, EMIT, FINISH} state_t;

    state_t           state, state_nx;
    logic [10:0]      node_addr;
    logic [1:0]       fcnt;
    logic [WCW-1:0]   wcnt;
    logic [7:0]       byte0, byte2, byte3;
    logic [10:0]      next_addr;
    logic             next_zero, next_mis, at_limit;

    // One entry per outstanding read: which byte of the node it returns.
    logic [READ_LATENCY-1:0]       vld_pipe;
    logic [READ_LATENCY-1:0][1:0]  idx_pipe;

    assign next_addr = {byte2[2:0], byte3};
    assign next_zero = (next_addr == 11'd0);
    assign next_mis  = (next_addr[1:0] != 2'b00);
    assign at_limit  = ((length + 11'd1) == 11'(MAX_NODES));

    // Channel B is only ever read.
    assign i_b_clk_en  = 1'b1;
    assign i_b_data_en = 1'b1;
    assign i_b_wr_en   = 1'b0;
    assign i_b_data    = 8'd0;

    assign pos_data = byte0;

    always_comb begin
        state_nx    = state;
        busy        = (state != IDLE);
        done        = (state == FINISH);
        pos_valid   = (state == EMIT);
        pos_last    = (state == EMIT) && next_zero;
        i_b_address = 11'd0;
        case (state)
            IDLE: begin
                if (start)
                    state_nx = (head_addr == 11'd0) ? FINISH : FETCH;
            end
            FETCH: begin
                i_b_address = node_addr + 11'(fcnt);
                if (fcnt == 2'd3)
                    state_nx = WAIT;
            end
            WAIT: begin
                // Last WAIT cycle is the one whose edge captures byte3.
                if (wcnt == WCW'(READ_LATENCY - 1))
                    state_nx = EMIT;
            end
            EMIT: begin
                if (pos_ready) begin
                    if (next_zero || next_mis || at_limit)
                        state_nx = FINISH;
                    else
                        state_nx = FETCH;
                end
            end
            FINISH: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            node_addr <= 11'd0;
            fcnt      <= 2'd0;
            wcnt      <= '0;
            err       <= ERR_NONE;
            length    <= 11'd0;
            byte0     <= 8'd0;
            byte2     <= 8'd0;
            byte3     <= 8'd0;
            // Dropping the pipe discards any reads still in flight.
            vld_pipe  <= '0;
            idx_pipe  <= '0;
        end else begin
            state <= state_nx;

            vld_pipe[0] <= (state == FETCH);
            idx_pipe[0] <= fcnt;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                idx_pipe[i] <= idx_pipe[i-1];
            end

            if (vld_pipe[READ_LATENCY-1]) begin
                case (idx_pipe[READ_LATENCY-1])
                    2'd0:    byte0 <= o_b_data;
                    2'd2:    byte2 <= o_b_data;
                    2'd3:    byte3 <= o_b_data;
                    default: ;
                endcase
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        node_addr <= head_addr;
                        length    <= 11'd0;
                        err       <= ERR_NONE;
                        fcnt      <= 2'd0;
                    end
                end
                FETCH: begin
                    fcnt <= fcnt + 2'd1;
                    wcnt <= '0;
                end
                WAIT: wcnt <= wcnt + WCW'(1);
                EMIT: begin
                    if (pos_ready) begin
                        length <= length + 11'd1;
                        if (next_zero)
                            err <= ERR_NONE;
                        else if (next_mis)
                            err <= ERR_MIS;
                        else if (at_limit)
                            err <= ERR_OVF;
                        else begin
                            node_addr <= next_addr;
                            fcnt      <= 2'd0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_greedy_snake_dpb_r.sv
// Testbench for greedy_snake_dpb_r: directed lists plus random lists, each
// checked against a list walk computed straight from the node format.
module tb_greedy_snake_dpb_r;

    localparam int RL   = 2;
    localparam int MAXN = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [10:0] head_addr = 11'd0;
    logic        pos_ready = 1'b0;
    logic        busy, done, pos_valid, pos_last;
    logic [1:0]  err;
    logic [10:0] length;
    logic [7:0]  pos_data;
    logic        i_b_clk_en, i_b_data_en, i_b_wr_en;
    logic [7:0]  i_b_data, o_b_data;
    logic [10:0] i_b_address;

    always #5 clk = ~clk;

    greedy_snake_dpb_r #(.READ_LATENCY(RL), .MAX_NODES(MAXN)) dut (
        .clk(clk), .rst(rst), .start(start), .head_addr(head_addr),
        .busy(busy), .done(done), .err(err), .length(length),
        .pos_valid(pos_valid), .pos_ready(pos_ready), .pos_data(pos_data),
        .pos_last(pos_last), .i_b_clk_en(i_b_clk_en), .i_b_data_en(i_b_data_en),
        .i_b_wr_en(i_b_wr_en), .i_b_data(i_b_data), .i_b_address(i_b_address),
        .o_b_data(o_b_data)
    );

    // Memory model: data for an address appears RL cycles later.
    logic [7:0]  mem [0:2047];
    logic [10:0] apipe [0:RL-1];
    always @(posedge clk) begin
        apipe[0] <= i_b_address;
        for (int i = 1; i < RL; i++) apipe[i] <= apipe[i-1];
    end
    assign o_b_data = mem[apipe[RL-1]];

    // Monitor: records what the DUT did; checks live in the main block.
    int          cyc = 0, done_cnt = 0, pv_cnt = 0, unstable = 0, chb_viol = 0;
    logic [7:0]  got_pos[$];
    logic        got_last[$];
    int          hs_cyc[$];
    logic [10:0] rd_q[$];
    logic        prev_v = 1'b0, prev_hs = 1'b0, prev_l = 1'b0;
    logic [7:0]  prev_d = 8'd0;

    always @(negedge clk) begin
        cyc++;
        if (done) done_cnt++;
        if (pos_valid) pv_cnt++;
        if (i_b_address != 11'd0) rd_q.push_back(i_b_address);
        if (i_b_wr_en !== 1'b0 || i_b_data !== 8'd0 || i_b_clk_en !== 1'b1 || i_b_data_en !== 1'b1)
            chb_viol++;
        if (!rst && prev_v && !prev_hs &&
            (!pos_valid || pos_data !== prev_d || pos_last !== prev_l))
            unstable++;
        if (pos_valid && pos_ready) begin
            got_pos.push_back(pos_data);
            got_last.push_back(pos_last);
            hs_cyc.push_back(cyc);
        end
        prev_v  = pos_valid;
        prev_hs = pos_valid && pos_ready;
        prev_d  = pos_data;
        prev_l  = pos_last;
    end

    // pos_ready driver: 0 always ready, 1 stall 5 cycles per node, 2 random.
    int rdy_mode = 0;
    int scnt = 0;
    initial forever begin
        @(posedge clk); #1;
        case (rdy_mode)
            0: pos_ready = 1'b1;
            1: begin
                if (!pos_valid) begin scnt = 0; pos_ready = 1'b0; end
                else if (scnt < 5) begin scnt++; pos_ready = 1'b0; end
                else pos_ready = 1'b1;
            end
            default: pos_ready = 1'($urandom_range(0, 1));
        endcase
    end

    int n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put_node(input logic [10:0] a, input logic [7:0] p, input logic [10:0] nx);
        mem[a]           = p;
        mem[11'(a + 1)]  = 8'($urandom);
        mem[11'(a + 2)]  = {5'($urandom), nx[10:8]};
        mem[11'(a + 3)]  = nx[7:0];
    endtask

    // Reference: walk the list exactly as the node format describes.
    logic [7:0] exp_pos[$];
    logic       exp_last[$];
    int         exp_err, exp_len;

    task automatic model(input logic [10:0] head);
        logic [10:0] a, nx;
        exp_pos.delete(); exp_last.delete();
        exp_err = 0; exp_len = 0;
        if (head == 11'd0) return;
        a = head;
        forever begin
            nx = {mem[11'(a + 2)][2:0], mem[11'(a + 3)]};
            exp_pos.push_back(mem[a]);
            exp_last.push_back(nx == 11'd0);
            exp_len++;
            if (nx == 11'd0) break;
            if (nx % 4 != 0) begin exp_err = 2; break; end
            if (exp_len == MAXN) begin exp_err = 1; break; end
            a = nx;
        end
    endtask

    // Full traversal; optional start pulse while busy that must be ignored.
    task automatic run(input string tag, input logic [10:0] head, input int mode, input bit poke);
        int pb, db, n;
        model(head);
        rdy_mode = mode;
        pb = got_pos.size();
        db = done_cnt;
        start = 1'b1; head_addr = head;
        @(posedge clk); #1;
        start = 1'b0;
        if (poke) begin
            repeat (3) begin @(posedge clk); #1; end
            start = 1'b1; head_addr = 11'h40;
            @(posedge clk); #1;
            start = 1'b0; head_addr = 11'd0;
        end
        n = 0;
        while (done_cnt == db && n < 3000) begin @(posedge clk); #1; n++; end
        check({tag, "/finished"}, 32'(n < 3000), 1);
        @(posedge clk); #1;
        check({tag, "/busy_low"}, 32'(busy), 0);
        check({tag, "/length"}, 32'(length), 32'(exp_len));
        check({tag, "/err"}, 32'(err), 32'(exp_err));
        check({tag, "/nodes"}, 32'(got_pos.size() - pb), 32'(exp_pos.size()));
        check({tag, "/done_pulses"}, 32'(done_cnt - db), 1);
        for (int i = 0; i < exp_pos.size(); i++) begin
            if (pb + i < got_pos.size()) begin
                check({tag, "/pos_data"}, 32'(got_pos[pb + i]), 32'(exp_pos[i]));
                check({tag, "/pos_last"}, 32'(got_last[pb + i]), 32'(exp_last[i]));
            end
        end
    endtask

    initial begin
        int hb, rb, pv, db, n, cnt, sel, nn;
        logic [10:0] a[8];
        logic [10:0] nx;

        for (int i = 0; i < 2048; i++) mem[i] = 8'd0;
        rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("rst/busy", 32'(busy), 0);
        check("rst/done", 32'(done), 0);
        check("rst/pos_valid", 32'(pos_valid), 0);
        check("rst/pos_last", 32'(pos_last), 0);
        check("rst/err", 32'(err), 0);
        check("rst/length", 32'(length), 0);
        check("rst/pos_data", 32'(pos_data), 0);
        check("rst/address", 32'(i_b_address), 0);
        check("rst/wr_en", 32'(i_b_wr_en), 0);
        check("rst/b_data", 32'(i_b_data), 0);
        check("rst/clk_en", 32'(i_b_clk_en), 1);
        check("rst/data_en", 32'(i_b_data_en), 1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Three-node list, always ready: 7 cycles between handshakes.
        put_node(11'd4, 8'h88, 11'd8);
        put_node(11'd8, 8'h78, 11'd12);
        put_node(11'd12, 8'h68, 11'd0);
        hb = hs_cyc.size();
        run("basic", 11'd4, 0, 1'b0);
        check("basic/first", 32'(got_pos[hb]), 32'h88);
        if (hs_cyc.size() >= hb + 3) begin
            check("basic/gap1", 32'(hs_cyc[hb + 1] - hs_cyc[hb]), 4 + RL + 1);
            check("basic/gap2", 32'(hs_cyc[hb + 2] - hs_cyc[hb + 1]), 4 + RL + 1);
        end

        // Empty list: FINISH directly after the start edge.
        rb = rd_q.size(); pv = pv_cnt; db = done_cnt;
        start = 1'b1; head_addr = 11'd0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("empty/done", 32'(done), 1);
        check("empty/busy", 32'(busy), 1);
        @(posedge clk); #1;
        check("empty/done_off", 32'(done), 0);
        check("empty/busy_off", 32'(busy), 0);
        check("empty/length", 32'(length), 0);
        check("empty/err", 32'(err), 0);
        check("empty/no_valid", 32'(pv_cnt - pv), 0);
        check("empty/no_reads", 32'(rd_q.size() - rb), 0);
        check("empty/done_pulses", 32'(done_cnt - db), 1);

        // Stalled consumer: payload stable, no refetch until handshake.
        rb = rd_q.size();
        run("stall", 11'd4, 1, 1'b0);
        check("stall/reads", 32'(rd_q.size() - rb), 12);
        check("stall/stable", 32'(unstable), 0);

        // Cycle 4 -> 8 -> 4 hits the node limit.
        put_node(11'd8, 8'h78, 11'd4);
        run("cyclic", 11'd4, 0, 1'b0);

        // Misaligned next pointer: one node, no read of it.
        put_node(11'd4, 8'h55, 11'h00A);
        rb = rd_q.size();
        run("misalign", 11'd4, 0, 1'b0);
        cnt = 0;
        for (int i = rb; i < rd_q.size(); i++) if (rd_q[i] == 11'h00A) cnt++;
        check("misalign/no_bad_read", 32'(cnt), 0);
        check("misalign/reads", 32'(rd_q.size() - rb), 4);

        // Reset in the middle of fetching node 2, then a clean rerun.
        put_node(11'd4, 8'h88, 11'd8);
        put_node(11'd8, 8'h78, 11'd12);
        rdy_mode = 0;
        start = 1'b1; head_addr = 11'd4;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (i_b_address != 11'd9 && n < 200);
        check("abort/reached_fetch2", 32'(n < 200), 1);
        db = done_cnt;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort/busy", 32'(busy), 0);
        check("abort/pos_valid", 32'(pos_valid), 0);
        check("abort/length", 32'(length), 0);
        repeat (10) begin @(posedge clk); #1; end
        check("abort/no_done", 32'(done_cnt - db), 0);
        check("abort/idle", 32'(busy), 0);
        run("rerun", 11'd4, 0, 1'b1);

        // Random lists with random backpressure.
        for (int it = 0; it < 6; it++) begin
            nn = $urandom_range(1, 6);
            for (int i = 0; i < nn; i++) a[i] = 11'((i + 1) * 128 + 4 * $urandom_range(0, 31));
            for (int i = 0; i < nn - 1; i++) put_node(a[i], 8'($urandom), a[i + 1]);
            sel = $urandom_range(0, 2);
            if (sel == 0)      nx = 11'd0;
            else if (sel == 1) nx = a[0] | 11'($urandom_range(1, 3));
            else               nx = a[0];
            put_node(a[nn - 1], 8'($urandom), nx);
            run("random", a[0], 2, 1'b0);
        end

        check("global/stable", 32'(unstable), 0);
        check("global/chan_b", 32'(chb_viol), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
